// File: rtl/rs_bank.sv
// ---------------------------------------------------------------------------
// rs_bank
//   A bank of WIDTH independent storage bits. Each cycle, MODE selects
//   whether every bit behaves as an RS, JK, D or T flip-flop. Forbidden RS
//   combinations (R=S=1 on any bit) set a sticky error flag and are counted
//   in a saturating counter.
//
// Parameters
//   WIDTH   number of storage bits
//   CNT_W   width of the forbidden-cycle counter
//   INIT    value loaded into Q on reset
//
// Ports
//   C        clock; all state changes on the rising edge
//   NRST     synchronous active-low reset
//   EN       update enable; 0 holds every register
//   MODE     element type: 00 RS, 01 JK, 10 D, 11 T
//   R        per-bit reset / K input (ignored in D and T modes)
//   S        per-bit set / J input, D data, or T toggle enable
//   Q        stored state
//   NQ       complement of Q
//   ERR      sticky flag: a forbidden RS cycle has been seen
//   ERR_CNT  saturating count of forbidden RS cycles
// ---------------------------------------------------------------------------
module rs_bank #(
  parameter int               WIDTH = 8,
  parameter int               CNT_W = 4,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             C,
  input  logic             NRST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] R,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] NQ,
  output logic             ERR,
  output logic [CNT_W-1:0] ERR_CNT
);

  typedef enum logic [1:0] {
    MODE_RS = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_d, q_q;
  logic             err_d, err_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  mode_e            mode;
  logic             forbidden;
  logic [WIDTH-1:0] rs_set;
  logic [WIDTH-1:0] rs_clr;

  assign mode = mode_e'(MODE);

  // A forbidden cycle is counted once no matter how many bits collide.
  assign forbidden = EN && (mode == MODE_RS) && ((R & S) != '0);

  // RS decode: bits with R=S=1 fall into neither mask, so they hold while
  // the other bits of the same cycle still update.
  assign rs_set = S & ~R;
  assign rs_clr = R & ~S;

  always_comb begin
    q_d   = q_q;
    err_d = err_q;
    cnt_d = cnt_q;

    if (EN) begin
      unique case (mode)
        MODE_RS: q_d = (q_q | rs_set) & ~rs_clr;
        MODE_JK: q_d = (S & ~q_q) | (~R & q_q);
        MODE_D:  q_d = S;
        MODE_T:  q_d = q_q ^ S;
        default: q_d = q_q;
      endcase
    end

    if (forbidden) begin
      err_d = 1'b1;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Reset wins over every other input, including a forbidden cycle on the
  // same edge, so that cycle is never counted.
  always_ff @(posedge C) begin
    if (!NRST) begin
      q_q   <= INIT;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign Q       = q_q;
  assign NQ      = ~q_q;
  assign ERR     = err_q;
  assign ERR_CNT = cnt_q;

endmodule

// File: tb/tb_rs_bank.sv
// ---------------------------------------------------------------------------
// tb_rs_bank
//   Scoreboard bench for rs_bank. Stimulus pushes the hand-computed
//   expected state for each vector into a queue; a monitor pops and compares
//   one entry after every edge that sampled a vector.
//   dut_a: WIDTH=8, CNT_W=4, INIT=8'hA5.
//   dut_b: WIDTH=8, CNT_W=2, INIT=8'h00 (held in reset until its own phase).
// ---------------------------------------------------------------------------
module tb_rs_bank;

  typedef struct packed {
    logic       sel;
    logic [7:0] q;
    logic       err;
    logic [3:0] cnt;
  } exp_t;

  logic       clk;
  logic       nrst_a;
  logic       nrst_b;
  logic       en;
  logic [1:0] mode;
  logic [7:0] r;
  logic [7:0] s;

  logic [7:0] q_a, nq_a;
  logic       err_a;
  logic [3:0] cnt_a;
  logic [7:0] q_b, nq_b;
  logic       err_b;
  logic [1:0] cnt_b;

  exp_t  exp_q[$];
  string lbl_q[$];
  exp_t  cur;
  string cur_lbl;
  bit    vec_valid;
  int    checks;
  int    errors;

  rs_bank #(.WIDTH(8), .CNT_W(4), .INIT(8'hA5)) dut_a (
    .C(clk), .NRST(nrst_a), .EN(en), .MODE(mode), .R(r), .S(s),
    .Q(q_a), .NQ(nq_a), .ERR(err_a), .ERR_CNT(cnt_a)
  );

  rs_bank #(.WIDTH(8), .CNT_W(2), .INIT(8'h00)) dut_b (
    .C(clk), .NRST(nrst_b), .EN(en), .MODE(mode), .R(r), .S(s),
    .Q(q_b), .NQ(nq_b), .ERR(err_b), .ERR_CNT(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compareField(input string lbl, input string fld,
                              input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s.%s actual=%h required=%h", lbl, fld, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e, input string lbl);
    if (e.sel == 1'b0) begin
      compareField(lbl, "Q",       q_a,               e.q);
      compareField(lbl, "NQ",      nq_a,              ~e.q);
      compareField(lbl, "ERR",     {7'd0, err_a},     {7'd0, e.err});
      compareField(lbl, "ERR_CNT", {4'd0, cnt_a},     {4'd0, e.cnt});
    end else begin
      compareField(lbl, "Q",       q_b,               e.q);
      compareField(lbl, "NQ",      nq_b,              ~e.q);
      compareField(lbl, "ERR",     {7'd0, err_b},     {7'd0, e.err});
      compareField(lbl, "ERR_CNT", {6'd0, cnt_b},     {4'd0, e.cnt});
    end
  endtask

  // Monitor: one expected entry per sampled vector, checked 1 time unit
  // after the edge that consumed it.
  always @(posedge clk) begin
    if (vec_valid) begin
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard_underflow actual=empty required=entry");
      end else begin
        cur     = exp_q.pop_front();
        cur_lbl = lbl_q.pop_front();
        checkOutput(cur, cur_lbl);
      end
    end
  end

  // Drives one vector at the falling edge and queues its expected result.
  // glitch pulses the selected reset low briefly between edges.
  task automatic applyStimulus(input bit sel, input bit nrst_v, input bit en_v,
                               input logic [1:0] mode_v, input logic [7:0] r_v,
                               input logic [7:0] s_v, input logic [7:0] eq,
                               input bit eerr, input logic [3:0] ecnt,
                               input string lbl, input bit glitch);
    exp_t e;
    @(negedge clk);
    if (sel) begin
      nrst_a = 1'b1;
      nrst_b = nrst_v;
    end else begin
      nrst_a = nrst_v;
      nrst_b = 1'b0;
    end
    en   = en_v;
    mode = mode_v;
    r    = r_v;
    s    = s_v;
    e.sel = sel;
    e.q   = eq;
    e.err = eerr;
    e.cnt = ecnt;
    exp_q.push_back(e);
    lbl_q.push_back(lbl);
    vec_valid = 1'b1;
    if (glitch) begin
      #1;
      if (sel) nrst_b = 1'b0; else nrst_a = 1'b0;
      #1;
      if (sel) nrst_b = 1'b1; else nrst_a = 1'b1;
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    vec_valid = 1'b0;
    nrst_a    = 1'b0;
    nrst_b    = 1'b0;
    en        = 1'b0;
    mode      = 2'b00;
    r         = 8'h00;
    s         = 8'h00;

    // Reset with a forbidden RS pattern present, then EN=0 with random data
    applyStimulus(0, 0, 1, 2'b00, 8'hFF, 8'hFF, 8'hA5, 0, 4'd0, "reset", 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 2'($urandom), 8'($urandom), 8'($urandom),
                    8'hA5, 0, 4'd0, $sformatf("en_off_%0d", i), 0);
    end

    // Clear via D mode, then RS set / clear / hold
    applyStimulus(0, 1, 1, 2'b10, 8'hFF, 8'h00, 8'h00, 0, 4'd0, "d_clear", 0);
    applyStimulus(0, 1, 1, 2'b00, 8'h00, 8'h0F, 8'h0F, 0, 4'd0, "rs_set",  0);
    applyStimulus(0, 1, 1, 2'b00, 8'h03, 8'h00, 8'h0C, 0, 4'd0, "rs_clr",  0);
    applyStimulus(0, 1, 1, 2'b00, 8'h00, 8'h00, 8'h0C, 0, 4'd0, "rs_hold", 0);

    // Forbidden RS: Q holds, ERR sticks, count increments
    applyStimulus(0, 1, 1, 2'b00, 8'h81, 8'h81, 8'h0C, 1, 4'd1, "rs_forbid",   0);
    applyStimulus(0, 1, 1, 2'b00, 8'h00, 8'h00, 8'h0C, 1, 4'd1, "err_sticky",  0);
    // Two bits forbidden plus an independent set on bit 1: counts once
    applyStimulus(0, 1, 1, 2'b00, 8'h81, 8'h83, 8'h0E, 1, 4'd2, "rs_mixed",    0);
    applyStimulus(0, 1, 0, 2'b00, 8'hFF, 8'hFF, 8'h0E, 1, 4'd2, "en_off_forb", 0);
    applyStimulus(0, 1, 1, 2'b00, 8'h02, 8'h00, 8'h0C, 1, 4'd2, "rs_clr_b1",   0);

    // JK toggle, T, D, JK mixed, T all
    applyStimulus(0, 1, 1, 2'b01, 8'hFF, 8'hFF, 8'hF3, 1, 4'd2, "jk_toggle", 0);
    applyStimulus(0, 1, 1, 2'b11, 8'hFF, 8'h01, 8'hF2, 1, 4'd2, "t_bit0",    0);
    applyStimulus(0, 1, 1, 2'b10, 8'hFF, 8'h3C, 8'h3C, 1, 4'd2, "d_load",    0);
    applyStimulus(0, 1, 1, 2'b01, 8'hF0, 8'h0F, 8'h0F, 1, 4'd2, "jk_mixed",  0);
    applyStimulus(0, 1, 1, 2'b11, 8'hAA, 8'hFF, 8'hF0, 1, 4'd2, "t_all",     0);

    // Reset overrides a forbidden cycle; JK R=S=FF never raises ERR
    applyStimulus(0, 0, 1, 2'b00, 8'hFF, 8'hFF, 8'hA5, 0, 4'd0, "reset_forb", 0);
    applyStimulus(0, 1, 1, 2'b01, 8'hFF, 8'hFF, 8'h5A, 0, 4'd0, "jk_no_err",  0);
    applyStimulus(0, 1, 1, 2'b00, 8'hFF, 8'hFF, 8'h5A, 1, 4'd1, "post_reset_forb", 0);
    applyStimulus(0, 1, 1, 2'b00, 8'h00, 8'h01, 8'h5B, 1, 4'd1, "rs_set_b0",  0);
    // Reset pulsed between edges only: no effect
    applyStimulus(0, 1, 0, 2'b00, 8'h00, 8'h00, 8'h5B, 1, 4'd1, "nrst_glitch", 1);

    // Saturation on the 2-bit counter instance
    applyStimulus(1, 0, 1, 2'b00, 8'hFF, 8'hFF, 8'h00, 0, 4'd0, "b_reset", 0);
    applyStimulus(1, 1, 1, 2'b00, 8'hFF, 8'hFF, 8'h00, 1, 4'd1, "b_sat_1", 0);
    applyStimulus(1, 1, 1, 2'b00, 8'hFF, 8'hFF, 8'h00, 1, 4'd2, "b_sat_2", 0);
    applyStimulus(1, 1, 1, 2'b00, 8'hFF, 8'hFF, 8'h00, 1, 4'd3, "b_sat_3", 0);
    applyStimulus(1, 1, 1, 2'b00, 8'hFF, 8'hFF, 8'h00, 1, 4'd3, "b_sat_4", 0);
    applyStimulus(1, 1, 1, 2'b00, 8'hFF, 8'hFF, 8'h00, 1, 4'd3, "b_sat_5", 0);

    @(negedge clk);
    vec_valid = 1'b0;
    repeat (3) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
